// File: rtl/sprite_palette_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_palette_arbiter
//
// Shares one combinational 16-entry x 12-bit sprite palette between two
// fighter sprite renderers (P1 and P2). Each requester offers a 4-bit palette
// index under a valid/ready handshake. A grant selects one requester per
// cycle, and the granted index is registered onto the shared palette
// (stage 1). The palette colour is then registered together with a
// transparency flag and the requester id (stage 2). Responses come out at a
// fixed latency, in grant order, with one response per accepted request.
//
// Ports:
//   Clk             in   system clock, rising edge
//   Reset_n         in   asynchronous active-low reset
//   frame_start     in   one-cycle pulse, returns the preference to P1
//   p1_valid/index  in   P1 request
//   p1_ready        out  P1 accepted this cycle (combinational)
//   p2_valid/index  in   P2 request
//   p2_ready        out  P2 accepted this cycle (combinational)
//   pal_index       out  registered index driven to the shared palette
//   pal_red/green/blue in palette colour, combinational from pal_index
//   rsp_valid       out  one-cycle response strobe
//   rsp_id          out  0 = P1, 1 = P2
//   rsp_red/green/blue out looked-up colour
//   rsp_transparent out  index matched TRANSPARENT_INDEX
//   busy            out  stage 1 or stage 2 holds a valid entry
// ---------------------------------------------------------------------------
module sprite_palette_arbiter #(
    parameter logic [3:0] TRANSPARENT_INDEX = 4'd1,
    parameter int         FIXED_PRIORITY    = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       p1_valid,
    input  logic [3:0] p1_index,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [3:0] p2_index,
    output logic       p2_ready,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_red,
    output logic [3:0] rsp_green,
    output logic [3:0] rsp_blue,
    output logic       rsp_transparent,
    output logic       busy
);

    // Returns 1 when the index is the colour-key (transparent) entry.
    function automatic logic is_transparent(input logic [3:0] idx);
        return (idx == TRANSPARENT_INDEX);
    endfunction

    // Preference pointer: 0 = P1 preferred, 1 = P2 preferred.
    logic       pref_p2_r;

    logic       grant_p1_s;
    logic       grant_p2_s;
    logic       accept_s;
    logic [3:0] grant_index_s;

    logic       s1_valid_r;
    logic       s1_id_r;
    logic [3:0] s1_index_r;

    logic       rsp_valid_r;
    logic       rsp_id_r;
    logic [3:0] rsp_red_r;
    logic [3:0] rsp_green_r;
    logic [3:0] rsp_blue_r;
    logic       rsp_transparent_r;
    logic       busy_r;

    // Grant selection: single requester always wins; contention goes to the
    // preferred side, or to P1 unconditionally in fixed-priority mode.
    always_comb begin
        grant_p1_s = 1'b0;
        grant_p2_s = 1'b0;
        case ({p1_valid, p2_valid})
            2'b10: grant_p1_s = 1'b1;
            2'b01: grant_p2_s = 1'b1;
            2'b11: begin
                if ((FIXED_PRIORITY != 0) || !pref_p2_r) begin
                    grant_p1_s = 1'b1;
                end else begin
                    grant_p2_s = 1'b1;
                end
            end
            default: begin
                grant_p1_s = 1'b0;
                grant_p2_s = 1'b0;
            end
        endcase
    end

    // Index of the granted requester, used to load stage 1.
    always_comb begin
        grant_index_s = p1_index;
        if (grant_p2_s) begin
            grant_index_s = p2_index;
        end else begin
            grant_index_s = p1_index;
        end
    end

    assign accept_s = grant_p1_s | grant_p2_s;
    assign p1_ready = grant_p1_s;
    assign p2_ready = grant_p2_s;

    // Preference pointer: frame_start wins over the grant-based rotation.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pref_p2_r <= 1'b0;
        end else if (frame_start) begin
            pref_p2_r <= 1'b0;
        end else if (grant_p1_s) begin
            pref_p2_r <= 1'b1;
        end else if (grant_p2_s) begin
            pref_p2_r <= 1'b0;
        end else begin
            pref_p2_r <= pref_p2_r;
        end
    end

    // Stage 1: latch the accepted request; the index holds when idle so the
    // palette address does not toggle needlessly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_index_r <= 4'd0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_id_r    <= grant_p2_s;
            s1_index_r <= grant_index_s;
        end else begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= s1_id_r;
            s1_index_r <= s1_index_r;
        end
    end

    assign pal_index = s1_index_r;

    // Stage 2: capture the palette colour looked up from the stage-1 index.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_r       <= 1'b0;
            rsp_id_r          <= 1'b0;
            rsp_red_r         <= 4'd0;
            rsp_green_r       <= 4'd0;
            rsp_blue_r        <= 4'd0;
            rsp_transparent_r <= 1'b0;
        end else if (s1_valid_r) begin
            rsp_valid_r       <= 1'b1;
            rsp_id_r          <= s1_id_r;
            rsp_red_r         <= pal_red;
            rsp_green_r       <= pal_green;
            rsp_blue_r        <= pal_blue;
            rsp_transparent_r <= is_transparent(s1_index_r);
        end else begin
            rsp_valid_r       <= 1'b0;
            rsp_id_r          <= rsp_id_r;
            rsp_red_r         <= rsp_red_r;
            rsp_green_r       <= rsp_green_r;
            rsp_blue_r        <= rsp_blue_r;
            rsp_transparent_r <= 1'b0;
        end
    end

    // Busy flag registered from the next-state of both pipeline valids.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= accept_s | s1_valid_r;
        end
    end

    assign rsp_valid       = rsp_valid_r;
    assign rsp_id          = rsp_id_r;
    assign rsp_red         = rsp_red_r;
    assign rsp_green       = rsp_green_r;
    assign rsp_blue        = rsp_blue_r;
    assign rsp_transparent = rsp_transparent_r;
    assign busy            = busy_r;

endmodule
